beep_synth: RTL and testbench

BEEP_SYNTH -- requirements
Module: beep_synth

---
 rtl/beep_pkg.sv | 24 ++
 rtl/beep_synth_if.sv | 24 ++
 rtl/note_period_lut.sv | 36 +++
 rtl/beep_synth.sv | 127 ++++++++++++
 tb/tb_beep_synth.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/beep_pkg.sv
// Shared definitions for the beep synthesiser: FSM encoding, note table constants
// and the constant function that turns a tone frequency into a clock-cycle period.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // Low-octave frequencies in Hz for degrees 1..7 (C D E F G A B).
    localparam int unsigned BASE_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

    localparam logic [2:0] OCT_LOW  = 3'b001;
    localparam logic [2:0] OCT_MID  = 3'b010;
    localparam logic [2:0] OCT_HIGH = 3'b100;
    localparam logic [2:0] DEG_REST = 3'd0;

    function automatic int unsigned period_of(input int unsigned clk_hz,
                                              input int unsigned freq_hz);
        return (freq_hz == 0) ? 0 : clk_hz / freq_hz;
    endfunction

endpackage

// File: rtl/beep_synth_if.sv
// Note request / buzzer status bundle between a note sequencer and beep_synth.
interface beep_synth_if #(
    parameter int DUR_W = 16
) ();
    logic             note_vld;
    logic             note_rdy;
    logic [5:0]       note_code;
    logic [DUR_W-1:0] note_dur;
    logic [3:0]       volume;
    logic             stop;
    logic             beep;
    logic             busy;
    logic             note_done;

    modport master (
        output note_vld, note_code, note_dur, volume, stop,
        input  note_rdy, beep, busy, note_done
    );

    modport slave (
        input  note_vld, note_code, note_dur, volume, stop,
        output note_rdy, beep, busy, note_done
    );
endinterface

// File: rtl/note_period_lut.sv
// Maps a note code to its tone period in clock cycles; every entry is an
// elaboration-time constant, so no run-time divider is built.
module note_period_lut
    import beep_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 18
) (
    input  logic [5:0]       note_code,
    output logic [CNT_W-1:0] period
);

    logic [CNT_W-1:0] tbl [3][8];
    logic [2:0]       degree;

    assign degree = note_code[2:0];

    for (genvar o = 0; o < 3; o++) begin : g_oct
        assign tbl[o][DEG_REST] = '0;
        for (genvar d = 1; d < 8; d++) begin : g_deg
            assign tbl[o][d] = CNT_W'(period_of(CLK_HZ, BASE_HZ[d-1] << o));
        end
    end

    // Anything that is not a clean one-hot octave plays as a rest.
    always_comb begin
        period = '0;
        case (note_code[5:3])
            OCT_LOW:  period = tbl[0][degree];
            OCT_MID:  period = tbl[1][degree];
            OCT_HIGH: period = tbl[2][degree];
            default:  period = '0;
        endcase
    end

endmodule

// File: rtl/beep_synth.sv
// Square-wave buzzer driver: plays one note at a time with volume set as duty
// cycle, times its length in milliseconds and reports natural completion.
module beep_synth
    import beep_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int CNT_W   = 18,
    parameter int DUR_W   = 16,
    parameter int VOL_MAX = 10
) (
    input  logic         sysclk,
    input  logic         rst_n,
    beep_synth_if.slave  bus
);

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYC - 1);
    localparam int PROD_W = CNT_W + 4;

    if (longint'(CLK_HZ / 262) >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
        $error("beep_synth: CNT_W=%0d cannot hold CLK_HZ/262", CNT_W);
    end

    state_t state_q, state_d;

    logic [5:0]       code_q;
    logic [DUR_W-1:0] dur_q;
    logic [3:0]       vol_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PRE_W-1:0] pre_q;
    logic [DUR_W-1:0] dur_cnt_q;
    logic             beep_q;
    logic             done_q;

    logic [CNT_W-1:0]  lut_period;
    logic [PROD_W-1:0] high_prod;
    logic [CNT_W-1:0]  high_len_d;
    logic [3:0]        vol_clamped;
    logic              accept;
    logic              ms_tick;
    logic              dur_last;
    logic              note_end;

    note_period_lut #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_lut (
        .note_code (code_q),
        .period    (lut_period)
    );

    assign vol_clamped = (bus.volume > 4'(VOL_MAX)) ? 4'(VOL_MAX) : bus.volume;
    assign accept      = (state_q == ST_IDLE) && bus.note_vld;
    assign high_prod   = PROD_W'(lut_period >> 1) * PROD_W'(vol_q);
    assign high_len_d  = CNT_W'(high_prod / PROD_W'(VOL_MAX));
    assign ms_tick     = (pre_q == PRE_LAST);
    assign dur_last    = (dur_cnt_q == dur_q - 1'b1);
    // A stop in the final millisecond takes priority over completion.
    assign note_end    = (state_q == ST_PLAY) && ms_tick && dur_last && !bus.stop;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysclk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.note_vld)          state_d = ST_LOAD;
            ST_LOAD: state_d = bus.stop ? ST_IDLE : ST_PLAY;
            ST_PLAY: if (bus.stop || note_end)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.note_rdy = (state_q == ST_IDLE);
        bus.busy     = (state_q == ST_LOAD) || (state_q == ST_PLAY);
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            code_q     <= '0;
            dur_q      <= '0;
            vol_q      <= '0;
            period_q   <= '0;
            high_len_q <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            dur_cnt_q  <= '0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (accept) begin
                code_q <= bus.note_code;
                dur_q  <= (bus.note_dur == '0) ? DUR_W'(1) : bus.note_dur;
                vol_q  <= vol_clamped;
            end
            if (state_q == ST_LOAD) begin
                period_q   <= lut_period;
                high_len_q <= high_len_d;
            end
            // Counters only run in PLAY, so LOAD always hands PLAY a zeroed set.
            if (state_q == ST_PLAY) begin
                cnt_q <= (period_q == '0 || cnt_q == period_q - 1'b1) ? '0 : cnt_q + 1'b1;
                pre_q <= ms_tick ? '0 : pre_q + 1'b1;
                if (ms_tick) dur_cnt_q <= dur_cnt_q + 1'b1;
            end else begin
                cnt_q     <= '0;
                pre_q     <= '0;
                dur_cnt_q <= '0;
            end
            beep_q <= (state_q == ST_PLAY) && !bus.stop && (period_q != '0) &&
                      (cnt_q < high_len_q);
            done_q <= note_end;
        end
    end

    assign bus.beep      = beep_q;
    assign bus.note_done = done_q;

endmodule

// File: tb/tb_beep_synth.sv
// Bench for beep_synth at 1 MHz: table of notes scored against a queue of
// expected waveform statistics, plus hand sequences for stop, back-to-back and reset.
module tb_beep_synth;

    localparam int CLK_HZ = 1_000_000;
    localparam int MS     = CLK_HZ / 1000;

    logic sysclk = 1'b0;
    logic rst_n;

    always #5 sysclk = ~sysclk;

    beep_synth_if #(.DUR_W(16)) bus ();

    beep_synth #(
        .CLK_HZ  (CLK_HZ),
        .CNT_W   (18),
        .DUR_W   (16),
        .VOL_MAX (10)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        string      name;
        logic [5:0] code;
        int         dur;
        int         vol;
        int         period;
    } vec_t;

    typedef struct {
        string name;
        int    lat;
        int    high;
        int    busy;
        int    first;
        int    max_run;
        int    gap;
    } exp_t;

    exp_t exp_q [$];
    vec_t vecs [10];

    int n_checks = 0;
    int n_pass   = 0;
    int now      = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Expected statistics of one completed note, derived from the tone period.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int ve, h, n, r;
        ve = (v.vol > 10) ? 10 : v.vol;
        h  = (v.period / 2) * ve / 10;
        n  = ((v.dur == 0) ? 1 : v.dur) * MS;
        e.name = v.name;
        e.lat  = 2 + n;
        e.busy = 1 + n;
        if (v.period == 0) begin
            e.high = 0;
        end else begin
            r = n % v.period;
            e.high = (n / v.period) * h + ((r < h) ? r : h);
        end
        e.first   = (v.period != 0 && h > 0) ? 3 : 0;
        e.max_run = (v.period != 0) ? h : 0;
        e.gap     = (v.period != 0 && h > 0 && n > v.period) ? v.period : 0;
        return e;
    endfunction

    // Monitor: measures each accepted note and scores it when note_done appears.
    int   cyc = 0, t_acc = 0, high_cnt = 0, busy_cnt = 0, first_off = 0;
    int   run = 0, max_run = 0, first_rise = 0, gap = 0, n_rise = 0;
    int   n_done = 0, n_acc = 0;
    bit   prev_beep = 1'b0;
    exp_t mon_e;

    always @(negedge sysclk) begin
        cyc++;
        if (bus.beep === 1'b1) begin
            high_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (!prev_beep) begin
                if (n_rise == 0) begin
                    first_off  = cyc - t_acc;
                    first_rise = cyc;
                end else if (n_rise == 1) begin
                    gap = cyc - first_rise;
                end
                n_rise++;
            end
        end else begin
            run = 0;
        end
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.note_done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("note_done with no note pending", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, " done latency"},  cyc - t_acc, mon_e.lat);
                check({mon_e.name, " high cycles"},   high_cnt,    mon_e.high);
                check({mon_e.name, " busy cycles"},   busy_cnt,    mon_e.busy);
                check({mon_e.name, " first high"},    first_off,   mon_e.first);
                check({mon_e.name, " high run"},      max_run,     mon_e.max_run);
                check({mon_e.name, " rise-to-rise"},  gap,         mon_e.gap);
            end
        end
        if (bus.note_vld === 1'b1 && bus.note_rdy === 1'b1) begin
            n_acc++;
            t_acc     = cyc;
            high_cnt  = 0;
            busy_cnt  = 0;
            first_off = 0;
            max_run   = 0;
            gap       = 0;
            n_rise    = 0;
        end
        prev_beep = (bus.beep === 1'b1);
    end

    task automatic step();
        @(posedge sysclk);
        #1;
        now++;
    endtask

    task automatic send_note(input logic [5:0] code, input int dur, input int vol);
        int guard;
        guard = 0;
        while (bus.note_rdy !== 1'b1 && guard < 5000) begin
            step();
            guard++;
        end
        check("note_rdy before send", bus.note_rdy, 1);
        bus.note_code = code;
        bus.note_dur  = 16'(dur);
        bus.volume    = 4'(vol);
        bus.note_vld  = 1'b1;
        step();
        bus.note_vld  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int k;
        k = 0;
        while (bus.note_done !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        check({name, " note_done seen"}, bus.note_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   done1, done_before, acc_before, highs, dones;
        exp_t e;
        vec_t v;

        vecs[0] = '{"lowA v10 d2",   6'b001_110, 2, 10, 2272};
        vecs[1] = '{"lowA v10 d3",   6'b001_110, 3, 10, 2272};
        vecs[2] = '{"lowA v5 d2",    6'b001_110, 2,  5, 2272};
        vecs[3] = '{"lowA v0 d1",    6'b001_110, 1,  0, 2272};
        vecs[4] = '{"rest d3",       6'b010_000, 3, 10,    0};
        vecs[5] = '{"highC v10 d1",  6'b100_001, 1, 10,  954};
        vecs[6] = '{"midE v15 d0",   6'b010_011, 0, 15, 1515};
        vecs[7] = '{"bad octave d1", 6'b011_101, 1, 10,    0};
        vecs[8] = '{"highB v7 d1",   6'b100_111, 1,  7,  506};
        vecs[9] = '{"lowC v3 d1",    6'b001_001, 1,  3, 3816};

        rst_n         = 1'b0;
        bus.note_vld  = 1'b0;
        bus.note_code = '0;
        bus.note_dur  = '0;
        bus.volume    = '0;
        bus.stop      = 1'b0;

        step();
        step();
        check("reset beep",      bus.beep,      0);
        check("reset busy",      bus.busy,      0);
        check("reset note_done", bus.note_done, 0);
        check("reset note_rdy",  bus.note_rdy,  1);
        rst_n = 1'b1;
        step();
        check("note_rdy after release", bus.note_rdy, 1);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            e = model(v);
            exp_q.push_back(e);
            send_note(v.code, v.dur, v.vol);
            wait_done(v.name, e.lat + 20);
            step();
            check({v.name, " beep low after"}, bus.beep,     0);
            check({v.name, " rdy after"},      bus.note_rdy, 1);
        end

        // stop while idle does nothing; a note offered alongside it is accepted
        bus.stop = 1'b1;
        step();
        step();
        check("idle stop keeps rdy", bus.note_rdy, 1);
        check("idle stop busy",      bus.busy,     0);
        v = '{"rest with idle stop", 6'b010_000, 1, 10, 0};
        exp_q.push_back(model(v));
        send_note(v.code, v.dur, v.vol);
        bus.stop = 1'b0;
        wait_done(v.name, 1100);
        step();

        // stop in LOAD
        done_before = n_done;
        send_note(6'b001_110, 2, 10);
        bus.stop = 1'b1;
        step();
        check("stop in LOAD busy", bus.busy,     0);
        check("stop in LOAD rdy",  bus.note_rdy, 1);
        bus.stop = 1'b0;
        step();
        check("stop in LOAD beep", bus.beep, 0);

        // stop 500 cycles into PLAY
        send_note(6'b001_110, 2, 10);
        step();
        repeat (500) step();
        check("beep high before stop", bus.beep, 1);
        bus.stop = 1'b1;
        step();
        check("stop in PLAY busy", bus.busy,     0);
        check("stop in PLAY beep", bus.beep,     0);
        check("stop in PLAY rdy",  bus.note_rdy, 1);
        bus.stop = 1'b0;
        highs = 0;
        repeat (30) begin
            step();
            if (bus.beep === 1'b1) highs++;
        end
        check("beep quiet after stop", highs, 0);

        // stop on the final cycle of a note
        send_note(6'b010_000, 1, 10);
        repeat (MS) step();
        check("busy on last PLAY cycle", bus.busy, 1);
        bus.stop = 1'b1;
        step();
        check("stop at end note_done", bus.note_done, 0);
        check("stop at end busy",      bus.busy,      0);
        bus.stop = 1'b0;
        step();
        step();
        check("no note_done from stopped notes", n_done, done_before);

        // note_vld held high across two notes
        v = '{"b2b highC", 6'b100_001, 1, 10, 954};
        exp_q.push_back(model(v));
        v = '{"b2b midG", 6'b010_101, 1, 10, 1275};
        exp_q.push_back(model(v));
        acc_before = n_acc;
        check("b2b rdy", bus.note_rdy, 1);
        bus.note_code = 6'b100_001;
        bus.note_dur  = 16'd1;
        bus.volume    = 4'd10;
        bus.note_vld  = 1'b1;
        step();
        bus.note_code = 6'b010_101;
        wait_done("b2b first", MS + 20);
        done1 = now;
        step();
        check("b2b second accepted at once", bus.busy, 1);
        bus.note_vld = 1'b0;
        wait_done("b2b second", MS + 20);
        check("b2b done spacing",  now - done1,        2 + MS);
        check("b2b accept count",  n_acc - acc_before, 2);
        step();

        // reset in the middle of PLAY
        done_before = n_done;
        send_note(6'b001_110, 2, 10);
        repeat (300) step();
        check("beep high before reset", bus.beep, 1);
        rst_n = 1'b0;
        step();
        check("mid reset beep",      bus.beep,      0);
        check("mid reset busy",      bus.busy,      0);
        check("mid reset note_done", bus.note_done, 0);
        check("mid reset rdy",       bus.note_rdy,  1);
        rst_n = 1'b1;
        step();
        check("rdy after mid reset",  bus.note_rdy, 1);
        check("busy after mid reset", bus.busy,     0);
        highs = 0;
        dones = 0;
        repeat (2 * MS + 100) begin
            step();
            if (bus.beep === 1'b1)      highs++;
            if (bus.note_done === 1'b1) dones++;
        end
        check("beep quiet after reset",   highs,  0);
        check("no done after reset",      dones,  0);
        check("done count after reset",   n_done, done_before);

        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
